// File: rtl/vx_fpu_tag_issue_if.sv
// vx_fpu_tag_issue_if: request, FPU issue/result and response channels of the FPU tag issue block.
// Supplies default widths for INST_FPU_BITS, INST_FRM_BITS and FP_FLAGS_BITS when not already defined.
`ifndef INST_FPU_BITS
`define INST_FPU_BITS 4
`endif
`ifndef INST_FRM_BITS
`define INST_FRM_BITS 3
`endif
`ifndef FP_FLAGS_BITS
`define FP_FLAGS_BITS 5
`endif

interface vx_fpu_tag_issue_if #(
    parameter int NUM_LANES = 1,
    parameter int TAGW      = 2,
    parameter int METAW     = 8
);
    logic                                    req_valid;
    logic                                    req_ready;
    logic [METAW-1:0]                        req_meta;
    logic [`INST_FPU_BITS-1:0]               req_op_type;
    logic [`INST_FRM_BITS-1:0]               req_frm;
    logic [NUM_LANES*32-1:0]                 req_dataa;
    logic [NUM_LANES*32-1:0]                 req_datab;
    logic                                    fpu_valid_in;
    logic                                    fpu_ready_in;
    logic [TAGW-1:0]                         fpu_tag_in;
    logic [`INST_FPU_BITS-1:0]               fpu_op_type;
    logic [`INST_FRM_BITS-1:0]               fpu_frm;
    logic [NUM_LANES*32-1:0]                 fpu_dataa;
    logic [NUM_LANES*32-1:0]                 fpu_datab;
    logic                                    fpu_valid_out;
    logic                                    fpu_ready_out;
    logic [TAGW-1:0]                         fpu_tag_out;
    logic [NUM_LANES*32-1:0]                 fpu_result;
    logic                                    fpu_has_fflags;
    logic [NUM_LANES*`FP_FLAGS_BITS-1:0]     fpu_fflags;
    logic                                    rsp_valid;
    logic                                    rsp_ready;
    logic [METAW-1:0]                        rsp_meta;
    logic [NUM_LANES*32-1:0]                 rsp_result;
    logic                                    rsp_has_fflags;
    logic [`FP_FLAGS_BITS-1:0]               rsp_fflags;
    logic [TAGW:0]                           inflight;
    logic                                    spurious_tag;
    logic                                    fflags_clr;
    logic [`FP_FLAGS_BITS-1:0]               fflags_acc;

    modport slave (
        input  req_valid, req_meta, req_op_type, req_frm, req_dataa, req_datab,
        input  fpu_ready_in, fpu_valid_out, fpu_tag_out, fpu_result, fpu_has_fflags, fpu_fflags,
        input  rsp_ready, fflags_clr,
        output req_ready, fpu_valid_in, fpu_tag_in, fpu_op_type, fpu_frm, fpu_dataa, fpu_datab,
        output fpu_ready_out, rsp_valid, rsp_meta, rsp_result, rsp_has_fflags, rsp_fflags,
        output inflight, spurious_tag, fflags_acc
    );

    modport master (
        output req_valid, req_meta, req_op_type, req_frm, req_dataa, req_datab,
        output fpu_ready_in, fpu_valid_out, fpu_tag_out, fpu_result, fpu_has_fflags, fpu_fflags,
        output rsp_ready, fflags_clr,
        input  req_ready, fpu_valid_in, fpu_tag_in, fpu_op_type, fpu_frm, fpu_dataa, fpu_datab,
        input  fpu_ready_out, rsp_valid, rsp_meta, rsp_result, rsp_has_fflags, rsp_fflags,
        input  inflight, spurious_tag, fflags_acc
    );
endinterface

// File: rtl/vx_fpu_tag_issue.sv
// vx_fpu_tag_issue: allocates tags for FPU requests, holds their metadata, and reorders nothing --
// results retire by tag into a one-entry response stage. Define FPU_FFLAGS_ACC_EN for a sticky fflags accumulator.
module vx_fpu_tag_issue #(
    parameter int NUM_LANES = 1,
    parameter int TAGW      = 2,
    parameter int METAW     = 8
) (
    input logic              clk,
    input logic              reset,
    vx_fpu_tag_issue_if.slave bus
);
    localparam int DEPTH = 1 << TAGW;
    localparam int FB    = `FP_FLAGS_BITS;

    logic [DEPTH-1:0]        busy;
    logic [METAW-1:0]        meta_store [DEPTH];
    logic [TAGW:0]           inflight_q;
    logic [TAGW-1:0]         free_tag;
    logic                    any_free, issue, fpu_rdy, rfire, retire, spurious_q;
    logic                    rsp_valid_q, rsp_hf_q;
    logic [METAW-1:0]        rsp_meta_q;
    logic [NUM_LANES*32-1:0] rsp_result_q;
    logic [FB-1:0]           rsp_ff_q, lane_ff, acc_q;

    always_comb begin
        free_tag = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!busy[i]) free_tag = TAGW'(i);
    end

    always_comb begin
        lane_ff = '0;
        for (int l = 0; l < NUM_LANES; l++)
            lane_ff = lane_ff | bus.fpu_fflags[l*FB +: FB];
    end

    assign any_free = ~&busy;
    assign issue    = bus.req_valid & any_free & bus.fpu_ready_in;
    assign fpu_rdy  = ~rsp_valid_q | bus.rsp_ready;
    assign rfire    = bus.fpu_valid_out & fpu_rdy;
    assign retire   = rfire & busy[bus.fpu_tag_out];

    assign bus.req_ready      = bus.fpu_ready_in & any_free;
    assign bus.fpu_valid_in   = bus.req_valid & any_free;
    assign bus.fpu_tag_in     = free_tag;
    assign bus.fpu_op_type    = bus.req_op_type;
    assign bus.fpu_frm        = bus.req_frm;
    assign bus.fpu_dataa      = bus.req_dataa;
    assign bus.fpu_datab      = bus.req_datab;
    assign bus.fpu_ready_out  = fpu_rdy;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_meta       = rsp_meta_q;
    assign bus.rsp_result     = rsp_result_q;
    assign bus.rsp_has_fflags = rsp_hf_q;
    assign bus.rsp_fflags     = rsp_ff_q;
    assign bus.inflight       = inflight_q;
    assign bus.spurious_tag   = spurious_q;
    assign bus.fflags_acc     = acc_q;

    // Issue tag comes from the pre-clear busy vector, so it never collides with a retiring tag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy         <= '0;
            inflight_q   <= '0;
            spurious_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_hf_q     <= 1'b0;
            rsp_ff_q     <= '0;
            rsp_meta_q   <= '0;
            rsp_result_q <= '0;
        end else begin
            busy       <= (busy & ~(DEPTH'(retire) << bus.fpu_tag_out)) | (DEPTH'(issue) << free_tag);
            inflight_q <= inflight_q + (TAGW+1)'(issue) - (TAGW+1)'(retire);
            if (rfire & ~retire) spurious_q <= 1'b1;
            if (fpu_rdy) rsp_valid_q <= bus.fpu_valid_out;
            if (rfire) begin
                rsp_meta_q   <= meta_store[bus.fpu_tag_out];
                rsp_result_q <= bus.fpu_result;
                rsp_hf_q     <= bus.fpu_has_fflags;
                rsp_ff_q     <= bus.fpu_has_fflags ? lane_ff : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) meta_store[free_tag] <= bus.req_meta;
    end

`ifdef FPU_FFLAGS_ACC_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) acc_q <= '0;
        else if (bus.fflags_clr) acc_q <= '0;
        else if (rsp_valid_q & bus.rsp_ready & rsp_hf_q) acc_q <= acc_q | rsp_ff_q;
    end
`else
    logic unused_fflags_clr;
    assign unused_fflags_clr = bus.fflags_clr;
    assign acc_q = '0;
`endif
endmodule

// File: doc/vx_fpu_tag_issue.md
VX_FPU_TAG_ISSUE -- requirements
Module: VX_fpu_tag_issue

Interface
REQ-001 SHALL have parameter NUM_LANES, default 1: lanes per request.
REQ-002 SHALL have parameter TAGW, default 2: tag width; tag pool depth DEPTH = 2^TAGW.
REQ-003 SHALL have parameter METAW, default 8: opaque per-request metadata width.
REQ-004 SHALL have port clk  in  1: single clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1: asynchronous, active-low reset.
REQ-006 SHALL have ports req_valid in 1, req_ready out 1: upstream request handshake.
REQ-007 SHALL have ports req_meta in METAW, req_op_type in `INST_FPU_BITS, req_frm in `INST_FRM_BITS, req_dataa/req_datab in NUM_LANES*32: request payload.
REQ-008 SHALL have ports fpu_valid_in out 1, fpu_ready_in in 1, fpu_tag_in out TAGW, fpu_op_type, fpu_frm, fpu_dataa, fpu_datab out: issue side to the FPU unit.
REQ-009 SHALL have ports fpu_valid_out in 1, fpu_ready_out out 1, fpu_tag_out in TAGW, fpu_result in NUM_LANES*32, fpu_has_fflags in 1, fpu_fflags in NUM_LANES*`FP_FLAGS_BITS: result side from the FPU unit.
REQ-010 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_meta out METAW, rsp_result out NUM_LANES*32, rsp_has_fflags out 1, rsp_fflags out `FP_FLAGS_BITS: upstream response.
REQ-011 SHALL have ports inflight out TAGW+1, spurious_tag out 1, fflags_clr in 1, fflags_acc out `FP_FLAGS_BITS.

Function
REQ-012 SHALL keep a DEPTH-bit busy vector and a DEPTH x METAW metadata store indexed by tag.
REQ-013 SHALL select the free tag as the lowest index with busy=0, computed from the registered busy vector.
REQ-014 SHALL drive fpu_valid_in = req_valid & any_free and req_ready = fpu_ready_in & any_free, combinationally; payload passes through unregistered.
REQ-015 SHALL on issue fire (fpu_valid_in & fpu_ready_in) set busy[tag] and write req_meta into the store at the next edge.
REQ-016 SHALL drive fpu_ready_out = ~rsp_valid | rsp_ready (one-entry registered response stage, full throughput).
REQ-017 SHALL on result fire load rsp_result, rsp_meta = store[fpu_tag_out], rsp_has_fflags, and rsp_fflags = OR over lanes of fpu_fflags gated by fpu_has_fflags; rsp_valid asserts next cycle; latency FPU-result to rsp_valid = 1 cycle.
REQ-018 SHALL clear busy[fpu_tag_out] on result fire; a tag freed in cycle N is allocatable no earlier than cycle N+1.
REQ-019 SHALL, on simultaneous issue and retire, apply both; issue tag is chosen from the pre-clear busy vector.
REQ-020 SHALL keep inflight = popcount(busy): +1 on issue only, -1 on retire only, unchanged on both; range 0..DEPTH.
REQ-021 SHALL hold req_ready=0 when inflight==DEPTH, independent of fpu_ready_in.
REQ-022 SHALL, on result fire with busy[fpu_tag_out]=0, set sticky spurious_tag, still forward the response, and leave busy/inflight unchanged; cleared only by reset.
REQ-023 SHALL hold rsp_* stable while rsp_valid & ~rsp_ready.

Reset
REQ-024 SHALL, on reset low, asynchronously clear busy, inflight, rsp_valid, rsp_has_fflags, rsp_fflags, spurious_tag, fflags_acc; rsp_meta/rsp_result reset to 0; metadata store not reset.
REQ-025 SHALL discard all outstanding tags on reset mid-operation; results arriving after reset deassertion with stale tags raise spurious_tag.

Configuration
REQ-026 SHALL, with FPU_FFLAGS_ACC_EN defined, OR rsp_fflags of each response fire (rsp_valid & rsp_ready & rsp_has_fflags) into sticky fflags_acc; fflags_clr clears it, clear wins over same-cycle set.
REQ-027 SHALL, without FPU_FFLAGS_ACC_EN, tie fflags_acc to 0 and ignore fflags_clr; ports remain present.

Verification
REQ-028 Single op: meta=8'hA5, fpu_ready_in=1, FPU returns tag 0 three cycles later -> fpu_tag_in=0, rsp_valid 1 cycle after result, rsp_meta=8'hA5, inflight 1 then 0.
REQ-029 Pool full: 4 issues, no results -> tags 0,1,2,3, inflight=4, req_ready=0; retire tag 2 -> next issue gets tag 2 one cycle later.
REQ-030 Out-of-order: issue meta 1,2,3; return tags 2,0,1 -> rsp_meta order 3,1,2.
REQ-031 Backpressure: rsp_ready=0 with rsp_valid=1 -> fpu_ready_out=0, rsp_* stable; rsp_ready=1 -> drain with back-to-back result accepted same cycle.
REQ-032 Spurious: result tag 3 while busy=0 -> spurious_tag=1, inflight stays 0.
REQ-033 FPU_FFLAGS_ACC_EN: responses with fflags 5'b10000 then 5'b00001 -> fflags_acc=5'b10001; fflags_clr pulse -> 0; macro undefined -> fflags_acc=0 throughout.
